// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/exception controller.
package hazard_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } hazState_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;
  localparam logic [31:0] ERET_CODE_DEF  = 32'h0000000E;

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard for long-latency producers; set beats clear, flush wipes all.
module hazard_scoreboard #(
  parameter int NREG = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            setEn,
  input  logic [REGW-1:0] setReg,
  input  logic            clrEn,
  input  logic [REGW-1:0] clrReg,
  input  logic            flushAll,
  input  logic [REGW-1:0] rdRegA,
  input  logic [REGW-1:0] rdRegB,
  output logic            rdA,
  output logic            rdB
);

  logic [NREG-1:0] sb;
  logic [NREG-1:0] sbNext;

  always_comb begin
    sbNext = sb;
    if (clrEn) sbNext[clrReg] = 1'b0;
    if (setEn) sbNext[setReg] = 1'b1;
    if (flushAll) sbNext = '0;
    sbNext[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) sb <= '0;
    else     sb <= sbNext;
  end

  assign rdA = sb[rdRegA];
  assign rdB = sb[rdRegB];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/exception controller for the 5-stage core: stalls, flushes, forwarding, redirect.
// Optional stall/exception counters are built when HAZ_PERF_EN is defined.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int          NREG       = 32,
  parameter int          REGW       = 5,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] ERET_CODE  = ERET_CODE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic            use_rsD,
  input  logic            use_rtD,
  input  logic            branchD,
  input  logic            issueD,
  input  logic [REGW-1:0] wregD,
  input  logic            long_latD,
  input  logic            regwriteE,
  input  logic            regwriteM,
  input  logic            regwriteW,
  input  logic [REGW-1:0] writeregE,
  input  logic [REGW-1:0] writeregM,
  input  logic [REGW-1:0] writeregW,
  input  logic            div_stallE,
  input  logic            inst_stall,
  input  logic            data_stall,
  input  logic [31:0]     exc_typeM,
  input  logic [31:0]     epcM,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
  output logic            stallM,
  output logic            flushD,
  output logic            flushE,
  output logic            flushM,
  output logic            flushW,
  output logic            fwdaD,
  output logic            fwdbD,
  output logic [1:0]      fwdaE,
  output logic [1:0]      fwdbE,
  output logic            redirect_valid,
  output logic [31:0]     redirect_pc,
  output logic [31:0]     perf_raw_cnt,
  output logic [31:0]     perf_mem_cnt,
  output logic [31:0]     perf_exc_cnt
);

  hazState_t       state, stateNext;
  logic            capture, fsmHold;
  logic            sbHitA, sbHitB, sbSet;
  logic            rawStall, brStall, frontStall;
  logic [REGW-1:0] rsE, rtE;

  function automatic logic [1:0] fwdSel(input logic [REGW-1:0] src,
                                        input logic rwM, input logic [REGW-1:0] wrM,
                                        input logic rwW, input logic [REGW-1:0] wrW);
    if (src != '0 && rwM && src == wrM)      return FWD_M;
    else if (src != '0 && rwW && src == wrW) return FWD_W;
    else                                     return FWD_RF;
  endfunction

  assign sbSet = issueD & long_latD & ~stallD & ~flushE & (wregD != '0);

  hazard_scoreboard #(.NREG(NREG), .REGW(REGW)) uScoreboard (
    .clk     (clk),
    .rst     (rst),
    .setEn   (sbSet),
    .setReg  (wregD),
    .clrEn   (regwriteW),
    .clrReg  (writeregW),
    .flushAll(capture),
    .rdRegA  (rsD),
    .rdRegB  (rtD),
    .rdA     (sbHitA),
    .rdB     (sbHitB)
  );

  assign rawStall = issueD & ((use_rsD & sbHitA) | (use_rtD & sbHitB));
  assign brStall  = branchD & regwriteE & (writeregE != '0) &
                    ((writeregE == rsD) | (writeregE == rtD));

  // Redirect FSM: capture is a one-cycle event out of IDLE; REDIR holds until fetch accepts
  always_comb begin
    stateNext      = state;
    capture        = 1'b0;
    fsmHold        = 1'b0;
    redirect_valid = 1'b0;
    case (state)
      IDLE: begin
        if (exc_typeM != '0) begin
          capture   = 1'b1;
          stateNext = REDIR;
        end
      end
      REDIR: begin
        redirect_valid = 1'b1;
        if (!inst_stall) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      redirect_pc <= EXC_VECTOR;
    end else begin
      state <= stateNext;
      if (capture) redirect_pc <= (exc_typeM == ERET_CODE) ? epcM : EXC_VECTOR;
    end
  end

  // Exception flush takes priority over every stall source
  always_comb begin
    frontStall = rawStall | brStall | inst_stall | data_stall | div_stallE | fsmHold;
    stallF = frontStall;
    stallD = frontStall;
    stallE = div_stallE | data_stall;
    stallM = data_stall;
    flushD = 1'b0;
    flushE = (rawStall | brStall) & ~(div_stallE | data_stall);
    flushM = 1'b0;
    flushW = data_stall;
    if (capture) begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      stallM = 1'b0;
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end
  end

  // E-stage copy of the decode sources, for the E operand muxes
  always_ff @(posedge clk) begin
    if (rst || flushE) begin
      rsE <= '0;
      rtE <= '0;
    end else if (!stallE) begin
      rsE <= rsD;
      rtE <= rtD;
    end
  end

  assign fwdaD = (rsD != '0) & regwriteM & (rsD == writeregM);
  assign fwdbD = (rtD != '0) & regwriteM & (rtD == writeregM);
  assign fwdaE = fwdSel(rsE, regwriteM, writeregM, regwriteW, writeregW);
  assign fwdbE = fwdSel(rtE, regwriteM, writeregM, regwriteW, writeregW);

`ifdef HAZ_PERF_EN
  logic [31:0] rawCnt, memCnt, excCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rawCnt <= '0;
      memCnt <= '0;
      excCnt <= '0;
    end else begin
      rawCnt <= rawCnt + {31'd0, rawStall | brStall};
      memCnt <= memCnt + {31'd0, inst_stall | data_stall};
      excCnt <= excCnt + {31'd0, capture};
    end
  end

  assign perf_raw_cnt = rawCnt;
  assign perf_mem_cnt = memCnt;
  assign perf_exc_cnt = excCnt;
`else
  assign perf_raw_cnt = 32'h0;
  assign perf_mem_cnt = 32'h0;
  assign perf_exc_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam logic [31:0] EXC_VEC = 32'hBFC00380;
  localparam logic [31:0] ERET    = 32'h0000000E;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rsD, rtD, wregD, writeregE, writeregM, writeregW;
  logic        use_rsD, use_rtD, branchD, issueD, long_latD;
  logic        regwriteE, regwriteM, regwriteW;
  logic        div_stallE, inst_stall, data_stall;
  logic [31:0] exc_typeM, epcM;
  logic        stallF, stallD, stallE, stallM;
  logic        flushD, flushE, flushM, flushW;
  logic        fwdaD, fwdbD;
  logic [1:0]  fwdaE, fwdbE;
  logic        redirect_valid;
  logic [31:0] redirect_pc, perf_raw_cnt, perf_mem_cnt, perf_exc_cnt;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .use_rsD(use_rsD), .use_rtD(use_rtD),
    .branchD(branchD), .issueD(issueD), .wregD(wregD), .long_latD(long_latD),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .div_stallE(div_stallE), .inst_stall(inst_stall), .data_stall(data_stall),
    .exc_typeM(exc_typeM), .epcM(epcM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .fwdaD(fwdaD), .fwdbD(fwdbD), .fwdaE(fwdaE), .fwdbE(fwdbE),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .perf_raw_cnt(perf_raw_cnt), .perf_mem_cnt(perf_mem_cnt), .perf_exc_cnt(perf_exc_cnt)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  // Reference state: pending-register set, redirect flag/target, E sources, counters
  bit   [31:0] mPend;
  bit          mRedir;
  logic [31:0] mPc;
  logic [4:0]  mRsE, mRtE;
  logic [31:0] mRaw, mMem, mExc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [1:0] fwdRef(input logic [4:0] r);
    if (r != 0 && regwriteM && r == writeregM) return 2'b10;
    if (r != 0 && regwriteW && r == writeregW) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clearInputs();
    rsD = 0; rtD = 0; wregD = 0; writeregE = 0; writeregM = 0; writeregW = 0;
    use_rsD = 0; use_rtD = 0; branchD = 0; issueD = 0; long_latD = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    div_stallE = 0; inst_stall = 0; data_stall = 0; exc_typeM = 0; epcM = 0;
  endtask

  // Checks every output against the model, then advances model and DUT one clock
  task automatic step();
    bit raw, br, cap, eStD, eStE, eStM, eFlD, eFlE, eFlM, eFlW, set;
    logic [31:0] eRawCnt, eMemCnt, eExcCnt;
    #1;
    raw = issueD && ((use_rsD && mPend[rsD]) || (use_rtD && mPend[rtD]));
    br  = branchD && regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD);
    cap = !mRedir && exc_typeM != 0;
    if (cap) begin
      {eStD, eStE, eStM} = 3'b000;
      {eFlD, eFlE, eFlM, eFlW} = 4'b1111;
    end else begin
      eStD = raw || br || inst_stall || data_stall || div_stallE;
      eStE = div_stallE || data_stall;
      eStM = data_stall;
      eFlD = 0; eFlM = 0;
      eFlE = (raw || br) && !eStE;
      eFlW = data_stall;
    end
`ifdef HAZ_PERF_EN
    eRawCnt = mRaw; eMemCnt = mMem; eExcCnt = mExc;
`else
    eRawCnt = 0; eMemCnt = 0; eExcCnt = 0;
`endif
    chk("stallF", {31'd0, stallF}, {31'd0, eStD});
    chk("stallD", {31'd0, stallD}, {31'd0, eStD});
    chk("stallE", {31'd0, stallE}, {31'd0, eStE});
    chk("stallM", {31'd0, stallM}, {31'd0, eStM});
    chk("flush", {28'd0, flushD, flushE, flushM, flushW}, {28'd0, eFlD, eFlE, eFlM, eFlW});
    chk("fwdD", {30'd0, fwdaD, fwdbD},
        {30'd0, rsD != 0 && regwriteM && rsD == writeregM, rtD != 0 && regwriteM && rtD == writeregM});
    chk("fwdaE", {30'd0, fwdaE}, {30'd0, fwdRef(mRsE)});
    chk("fwdbE", {30'd0, fwdbE}, {30'd0, fwdRef(mRtE)});
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, mRedir});
    chk("redirect_pc", redirect_pc, mPc);
    chk("perf_raw", perf_raw_cnt, eRawCnt);
    chk("perf_mem", perf_mem_cnt, eMemCnt);
    chk("perf_exc", perf_exc_cnt, eExcCnt);
    @(posedge clk);
    if (rst) begin
      mPend = 0; mRedir = 0; mPc = EXC_VEC; mRsE = 0; mRtE = 0;
      mRaw = 0; mMem = 0; mExc = 0;
    end else begin
      mRaw = mRaw + ((raw || br) ? 1 : 0);
      mMem = mMem + ((inst_stall || data_stall) ? 1 : 0);
      mExc = mExc + (cap ? 1 : 0);
      set = issueD && long_latD && !eStD && !eFlE && wregD != 0;
      if (cap) begin
        mPend = 0;
        mRedir = 1;
        mPc = (exc_typeM == ERET) ? epcM : EXC_VEC;
      end else begin
        if (regwriteW) mPend[writeregW] = 0;
        if (set) mPend[wregD] = 1;
        if (mRedir && !inst_stall) mRedir = 0;
      end
      mPend[0] = 0;
      if (eFlE) begin mRsE = 0; mRtE = 0; end
      else if (!eStE) begin mRsE = rsD; mRtE = rtD; end
    end
    @(negedge clk);
  endtask

  int vldCycles;

  initial begin
    clearInputs();
    rst = 1;
    mPend = 0; mRedir = 0; mPc = EXC_VEC; mRsE = 0; mRtE = 0;
    mRaw = 0; mMem = 0; mExc = 0;
    @(negedge clk);
    step(); step();
    rst = 0;
    chk("reset_pc", redirect_pc, EXC_VEC);

    // Load-use: lw $5 then addu $6,$5,$5 stalls until $5 is written back
    issueD = 1; long_latD = 1; wregD = 5;
    step();
    long_latD = 0; wregD = 6; use_rsD = 1; use_rtD = 1; rsD = 5; rtD = 5;
    #1 chk("lw_use_stallD", {31'd0, stallD}, 32'd1);
    chk("lw_use_flushE", {31'd0, flushE}, 32'd1);
    step(); step();
    regwriteW = 1; writeregW = 5;
    step();
    regwriteW = 0;
    #1 chk("lw_use_release", {31'd0, stallD}, 32'd0);
    step();

    // Branch on a register produced in E, then forwarded from M
    clearInputs();
    branchD = 1; use_rsD = 1; rsD = 4; regwriteE = 1; writeregE = 4;
    #1 chk("br_stall", {31'd0, stallD}, 32'd1);
    step();
    regwriteE = 0; writeregE = 0; regwriteM = 1; writeregM = 4;
    #1 chk("br_fwdaD", {30'd0, fwdaD, stallD}, 32'd2);
    step();

    // Same-cycle set/clear of reg 7: set wins; reg 0 never pending
    clearInputs();
    issueD = 1; long_latD = 1; wregD = 7; regwriteW = 1; writeregW = 7;
    step();
    clearInputs();
    issueD = 1; use_rsD = 1; rsD = 7;
    #1 chk("sb7_set_wins", {31'd0, stallD}, 32'd1);
    step();
    clearInputs();
    issueD = 1; long_latD = 1; wregD = 0;
    step();
    issueD = 1; long_latD = 0; use_rsD = 1; rsD = 0;
    #1 chk("reg0_no_stall", {31'd0, stallD}, 32'd0);
    step();

    // Ordinary exception clears the scoreboard and redirects to the vector
    clearInputs();
    exc_typeM = 32'h1;
    #1 chk("exc_flush", {28'd0, flushD, flushE, flushM, flushW}, 32'hF);
    step();
    exc_typeM = 0; issueD = 1; use_rsD = 1; rsD = 7;
    #1 chk("exc_pc", redirect_pc, EXC_VEC);
    chk("exc_sb_clear", {31'd0, stallD}, 32'd0);
    step();
    clearInputs();
    step();

    // ERET with fetch stalled three cycles keeps redirect up for four
    exc_typeM = ERET; epcM = 32'h80001000;
    step();
    exc_typeM = 0; vldCycles = 0;
    for (int i = 0; i < 6; i++) begin
      inst_stall = (i < 3);
      #1 if (redirect_valid) vldCycles++;
      if (i == 0) chk("eret_pc", redirect_pc, 32'h80001000);
      step();
    end
    chk("eret_valid_cycles", vldCycles, 4);

    // Reset while redirecting drops back to idle
    clearInputs();
    exc_typeM = 32'h4;
    step();
    exc_typeM = 0; inst_stall = 1; rst = 1;
    step();
    rst = 0; inst_stall = 0;
    #1 chk("rst_in_redir", {31'd0, redirect_valid}, 32'd0);
    step();

    // Data-side stall
    data_stall = 1;
    #1 chk("data_stall", {26'd0, stallF, stallD, stallE, stallM, flushW, flushE}, 32'h3E);
    step(); step(); step();
    clearInputs();
    step();

    // Randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      rsD        = 5'($urandom_range(0, 7));
      rtD        = 5'($urandom_range(0, 7));
      wregD      = 5'($urandom_range(0, 7));
      writeregE  = 5'($urandom_range(0, 7));
      writeregM  = 5'($urandom_range(0, 7));
      writeregW  = 5'($urandom_range(0, 7));
      issueD     = ($urandom_range(0, 9) < 8);
      long_latD  = ($urandom_range(0, 3) == 0);
      use_rsD    = ($urandom_range(0, 9) < 7);
      use_rtD    = ($urandom_range(0, 9) < 6);
      branchD    = ($urandom_range(0, 4) == 0);
      regwriteE  = ($urandom_range(0, 9) < 6);
      regwriteM  = ($urandom_range(0, 9) < 6);
      regwriteW  = ($urandom_range(0, 9) < 6);
      div_stallE = ($urandom_range(0, 19) == 0);
      inst_stall = ($urandom_range(0, 9) == 0);
      data_stall = ($urandom_range(0, 9) == 0);
      epcM       = $urandom;
      case ($urandom_range(0, 39))
        0:       exc_typeM = ERET;
        1:       exc_typeM = 32'($urandom_range(1, 31));
        default: exc_typeM = 0;
      endcase
      step();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
